// File: rtl/mac_r_gmii_frm.sv
// mac_r_gmii_frm -- receive-side GMII framer.
//
// Strips preamble/SFD and the 4-byte FCS from the GMII receive stream. Frame
// bytes go to the 8-bit data FIFO. At end of frame, one 16-bit
// {crc_err, long, short, rx_er, 1'b0, len[10:0]} word goes to the pointer FIFO.
//
// Ports
//   clk, rstn        system clock; synchronous active-low reset
//   gm_rx_dv/er/d    GMII receive (already in clk domain)
//   data_fifo_wr     data FIFO write strobe
//   data_fifo_dout   data FIFO byte
//   data_fifo_depth  data FIFO occupancy, used for admission
//   ptr_fifo_wr      pointer FIFO write strobe
//   ptr_fifo_dout    pointer FIFO length/status word
//   ptr_fifo_full    pointer FIFO full, used for admission
//   rx_frame_cnt     frames committed (wraps)
//   rx_drop_cnt      frames dropped (wraps)
//
// Build option
//   RX_CRC_CHECK_EN  builds the CRC-32 checker. When it is undefined,
//                    ptr bit 15 is tied to 0.

module mac_r_gmii_frm #(
  parameter int MAX_LEN    = 1514,
  parameter int MIN_LEN    = 60,
  parameter int FIFO_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        gm_rx_dv,
  input  logic        gm_rx_er,
  input  logic [7:0]  gm_rx_d,
  output logic        data_fifo_wr,
  output logic [7:0]  data_fifo_dout,
  input  logic [11:0] data_fifo_depth,
  output logic        ptr_fifo_wr,
  output logic [15:0] ptr_fifo_dout,
  input  logic        ptr_fifo_full,
  output logic [15:0] rx_frame_cnt,
  output logic [15:0] rx_drop_cnt
);

  localparam int          STAGES = 3;  // 4-byte FCS delay line
  localparam logic [7:0]  PRE_B  = 8'h55;
  localparam logic [7:0]  SFD_B  = 8'hD5;
  localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);
  localparam logic [10:0] LEN_MIN = 11'(MIN_LEN);

  typedef enum logic [2:0] {IDLE, PRE, DATA, END, DROP} state_t;

  typedef struct packed {
    logic        crc_err;
    logic        is_long;
    logic        is_short;
    logic        rx_er;
    logic        rsvd;
    logic [10:0] len;
  } ptr_word_t;

  state_t              state, nxt;
  logic [STAGES:0][7:0] dly;
  logic [STAGES:0]     vld_pipe;
  logic [10:0]         len;
  logic                is_long, rx_er;
  logic                crc_err;
  logic [12:0]         need;
  logic                admit, sfd_ok;
  ptr_word_t           word;

  // The SFD may be accepted only if a maximum-length frame still fits.
  assign need   = {1'b0, data_fifo_depth} + 13'(MAX_LEN);
  assign admit  = !ptr_fifo_full && (need <= 13'(FIFO_DEPTH));
  assign sfd_ok = gm_rx_dv && (gm_rx_d == SFD_B) &&
                  ((state == IDLE) || (state == PRE)) && admit;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (gm_rx_dv) begin
        if (gm_rx_d == PRE_B)      nxt = PRE;
        else if (gm_rx_d == SFD_B) nxt = admit ? DATA : DROP;
        else                       nxt = DROP;
      end
      PRE: begin
        if (!gm_rx_dv)             nxt = IDLE;
        else if (gm_rx_d == PRE_B) nxt = PRE;
        else if (gm_rx_d == SFD_B) nxt = admit ? DATA : DROP;
        else                       nxt = DROP;
      end
      DATA: if (!gm_rx_dv) nxt = END;
      END:  nxt = IDLE;
      DROP: if (!gm_rx_dv) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // ---------------- CRC-32 ----------------
`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc, crc_nxt, crc_rev;

  always_comb begin
    crc_nxt = crc ^ {24'h0, gm_rx_d};
    for (int i = 0; i < 8; i++)
      crc_nxt = crc_nxt[0] ? ((crc_nxt >> 1) ^ 32'hEDB88320) : (crc_nxt >> 1);
  end

  // The register is shifted LSB-first. The good-frame residue therefore
  // appears bit-reversed. Compare it in the usual normal-order form.
  always_comb begin
    crc_rev = '0;
    for (int i = 0; i < 32; i++) crc_rev[i] = crc[31-i];
  end

  always_ff @(posedge clk) begin
    if (!rstn)                          crc <= 32'hFFFF_FFFF;
    else if (sfd_ok)                    crc <= 32'hFFFF_FFFF;
    else if (state == DATA && gm_rx_dv) crc <= crc_nxt;
  end

  assign crc_err = (crc_rev != 32'hC704_DD7B);
`else
  assign crc_err = 1'b0;
`endif

  // The status word is built at the dv=0 edge. An error on that same cycle
  // still counts.
  always_comb begin
    word          = '0;
    word.crc_err  = crc_err;
    word.is_long  = is_long;
    word.is_short = (len < LEN_MIN);
    word.rx_er    = rx_er | gm_rx_er;
    word.len      = len;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_fifo_wr   <= 1'b0;
      data_fifo_dout <= '0;
      ptr_fifo_wr    <= 1'b0;
      ptr_fifo_dout  <= '0;
      rx_frame_cnt   <= '0;
      rx_drop_cnt    <= '0;
      dly            <= '0;
      vld_pipe       <= '0;
      len            <= '0;
      is_long        <= 1'b0;
      rx_er          <= 1'b0;
    end else begin
      data_fifo_wr <= 1'b0;
      ptr_fifo_wr  <= 1'b0;

      if (sfd_ok) begin
        vld_pipe <= '0;
        len      <= '0;
        is_long  <= 1'b0;
        rx_er    <= 1'b0;
      end

      case (state)
        DATA: begin
          if (gm_rx_er) rx_er <= 1'b1;
          if (gm_rx_dv) begin
            dly      <= {dly[STAGES-1:0], gm_rx_d};
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
            // Once the line is full, the oldest byte cannot be FCS.
            if (vld_pipe[STAGES]) begin
              if (len == LEN_MAX) begin
                is_long <= 1'b1;
              end else begin
                data_fifo_wr   <= 1'b1;
                data_fifo_dout <= dly[STAGES];
                len            <= len + 11'd1;
              end
            end
          end else if (len != '0) begin
            ptr_fifo_wr   <= 1'b1;
            ptr_fifo_dout <= word;
            rx_frame_cnt  <= rx_frame_cnt + 16'd1;
          end else begin
            rx_drop_cnt <= rx_drop_cnt + 16'd1;
          end
        end
        DROP: if (!gm_rx_dv) rx_drop_cnt <= rx_drop_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_r_gmii_frm.sv
// Scoreboard bench for mac_r_gmii_frm. Stimulus pushes the expected data
// bytes and pointer words. A negedge monitor pops and compares them.
module tb_mac_r_gmii_frm;

  logic        clk = 1'b0;
  logic        rstn;
  logic        gm_rx_dv, gm_rx_er;
  logic [7:0]  gm_rx_d;
  logic        data_fifo_wr;
  logic [7:0]  data_fifo_dout;
  logic [11:0] data_fifo_depth;
  logic        ptr_fifo_wr;
  logic [15:0] ptr_fifo_dout;
  logic        ptr_fifo_full;
  logic [15:0] rx_frame_cnt, rx_drop_cnt;

  always #5 clk = ~clk;

  mac_r_gmii_frm dut (
    .clk(clk), .rstn(rstn),
    .gm_rx_dv(gm_rx_dv), .gm_rx_er(gm_rx_er), .gm_rx_d(gm_rx_d),
    .data_fifo_wr(data_fifo_wr), .data_fifo_dout(data_fifo_dout),
    .data_fifo_depth(data_fifo_depth),
    .ptr_fifo_wr(ptr_fifo_wr), .ptr_fifo_dout(ptr_fifo_dout),
    .ptr_fifo_full(ptr_fifo_full),
    .rx_frame_cnt(rx_frame_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  logic [7:0]  frm[$];
  logic [7:0]  exp_data[$];
  logic [15:0] exp_ptr[$];
  int checks = 0, errors = 0;
  int exp_frames = 0, exp_drops = 0;

`ifdef RX_CRC_CHECK_EN
  localparam logic [15:0] BAD_CRC_WORD = 16'h803C;
`else
  localparam logic [15:0] BAD_CRC_WORD = 16'h003C;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Payload of n bytes, proper FCS appended LSB first, optional bit flip.
  task automatic mk_frame(input int n, input int flip_at);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      b = 8'((i * 37 + 11) ^ (i >> 3));
      frm.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    frm.push_back(c[7:0]);   frm.push_back(c[15:8]);
    frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    if (flip_at >= 0) frm[flip_at] = frm[flip_at] ^ 8'h04;
  endtask

  task automatic expect_frame(input int nw, input logic [15:0] ptr, input bit has_ptr);
    for (int i = 0; i < nw; i++) exp_data.push_back(frm[i]);
    if (has_ptr) exp_ptr.push_back(ptr);
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    gm_rx_dv = dv; gm_rx_er = er; gm_rx_d = d;
    @(posedge clk); #1;
  endtask

  task automatic send(input int er_at, input int rst_at);
    repeat (7) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == rst_at) begin
        rstn = 1'b0;
        drive(1'b1, 1'b0, frm[i]);
        drive(1'b0, 1'b0, 8'h00);
        rstn = 1'b1;
        return;
      end
      drive(1'b1, (i == er_at), frm[i]);
    end
    repeat (12) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_cnt"}, 32'(rx_frame_cnt), 32'(exp_frames));
    chk({tag, "_drop_cnt"},  32'(rx_drop_cnt),  32'(exp_drops));
  endtask

  // Monitor
  initial forever begin
    @(negedge clk);
    if (data_fifo_wr === 1'b1) begin
      if (exp_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL data_unexpected actual=%0h required=none", data_fifo_dout);
      end else chk("data_byte", 32'(data_fifo_dout), 32'(exp_data.pop_front()));
    end
    if (ptr_fifo_wr === 1'b1) begin
      if (exp_ptr.size() == 0) begin
        checks++; errors++;
        $display("FAIL ptr_unexpected actual=%0h required=none", ptr_fifo_dout);
      end else chk("ptr_word", 32'(ptr_fifo_dout), 32'(exp_ptr.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; gm_rx_dv = 1'b0; gm_rx_er = 1'b0; gm_rx_d = 8'h00;
    data_fifo_depth = 12'd0; ptr_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_wr",   32'(data_fifo_wr),   0);
    chk("rst_data_dout", 32'(data_fifo_dout), 0);
    chk("rst_ptr_wr",    32'(ptr_fifo_wr),    0);
    chk("rst_ptr_dout",  32'(ptr_fifo_dout),  0);
    chk("rst_frame_cnt", 32'(rx_frame_cnt),   0);
    chk("rst_drop_cnt",  32'(rx_drop_cnt),    0);
    rstn = 1'b1;
    drive(1'b0, 1'b0, 8'h00);

    // Good 60-byte frame
    mk_frame(60, -1); expect_frame(60, 16'h003C, 1'b1); send(-1, -1);
    exp_frames++; check_counts("good60");

    // One payload bit flipped
    mk_frame(60, 5); expect_frame(60, BAD_CRC_WORD, 1'b1); send(-1, -1);
    exp_frames++; check_counts("badcrc");

    // No room in the data FIFO -> dropped; accepted again once it drains
    data_fifo_depth = 12'd2600;
    mk_frame(60, -1); send(-1, -1);
    exp_drops++; check_counts("nospace");
    data_fifo_depth = 12'd0;
    expect_frame(60, 16'h003C, 1'b1); send(-1, -1);
    exp_frames++; check_counts("afterspace");

    // Oversize: 1514 bytes stored, long flag set
    mk_frame(1600, -1); expect_frame(1514, 16'h45EA, 1'b1); send(-1, -1);
    exp_frames++; check_counts("long");

    // Short with rx_er pulse
    mk_frame(40, -1); expect_frame(40, 16'h3028, 1'b1); send(20, -1);
    exp_frames++; check_counts("short_er");

    // Only FCS after SFD -> len 0, dropped
    mk_frame(0, -1); send(-1, -1);
    exp_drops++; check_counts("len0");

    // Junk byte in IDLE -> drop
    repeat (3) drive(1'b1, 1'b0, 8'hAB);
    repeat (12) drive(1'b0, 1'b0, 8'h00);
    exp_drops++; check_counts("junk");

    // Preamble abort: no side effects
    repeat (3) drive(1'b1, 1'b0, 8'h55);
    repeat (12) drive(1'b0, 1'b0, 8'h00);
    check_counts("pre_abort");

    // Back-to-back, reset during the second frame after 30 bytes
    mk_frame(60, -1); expect_frame(60, 16'h003C, 1'b1); send(-1, -1);
    exp_frames++; check_counts("b2b_first");
    mk_frame(60, -1); expect_frame(26, 16'h0000, 1'b0); send(-1, 30);
    exp_frames = 0; exp_drops = 0;
    chk("post_rst_data_wr",   32'(data_fifo_wr),   0);
    chk("post_rst_data_dout", 32'(data_fifo_dout), 0);
    chk("post_rst_ptr_wr",    32'(ptr_fifo_wr),    0);
    chk("post_rst_ptr_dout",  32'(ptr_fifo_dout),  0);
    check_counts("post_rst");
    repeat (12) drive(1'b0, 1'b0, 8'h00);

    chk("data_q_left", 32'(exp_data.size()), 0);
    chk("ptr_q_left",  32'(exp_ptr.size()),  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
